// File: rtl/mem_map_pkg.sv
// Address map and register layout shared by the data-memory responder blocks.
// Latency: n/a (constants, types and a pure decode function only).
// Backpressure: n/a.
package mem_map_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;

    // Word offsets inside the 16-word MMIO page
    localparam logic [3:0] OFF_CONSOLE  = 4'd0;
    localparam logic [3:0] OFF_STATUS   = 4'd1;
    localparam logic [3:0] OFF_TIMER_LO = 4'd2;
    localparam logic [3:0] OFF_TIMER_HI = 4'd3;

    // STATUS register bit positions
    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_OVF   = 2;

    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_MMIO = 2'd1,
        REG_NONE = 2'd2
    } region_e;

    // RAM wins below ram_limit; the MMIO page is matched on the upper 11 address bits
    function automatic region_e decode_region(
        input logic [ADDR_W-1:0] addr,
        input logic [ADDR_W-1:0] ram_limit,
        input logic [ADDR_W-1:0] mmio_base
    );
        region_e r;
        r = REG_NONE;
        if (addr < ram_limit) begin
            r = REG_RAM;
        end else if (addr[ADDR_W-1:4] == mmio_base[ADDR_W-1:4]) begin
            r = REG_MMIO;
        end
        return r;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Synchronous FIFO for console bytes: head is presented from storage, no fall-through.
// Latency: a pushed byte appears at head the cycle after the push edge.
// Backpressure: push when full is dropped (flagged on push_drop) unless a pop happens on the same edge.
module tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic             push_drop,
    output logic [WIDTH-1:0] head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [WIDTH-1:0] store [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Flags, accept/drop decision and next pointer/count values
    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == CW'(DEPTH));
        do_pop    = pop && !empty && !rst;
        do_push   = push && (!full || do_pop) && !rst;
        push_drop = push && full && !do_pop && !rst;
        head      = empty ? '0 : store[rd_ptr_q];

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Byte storage; contents are don't-care while empty so it is never cleared
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// CPU data-memory responder: word RAM plus MMIO page (console TX FIFO, STATUS, optional timer via MEM_RESP_TIMER_EN).
// Latency: zero wait states, read data registered and valid exactly one cycle after the address.
// Backpressure: none toward the CPU; console bytes wait in the FIFO for tx_ready, pushes into a full FIFO are dropped and flagged.
module mem_responder
    import mem_map_pkg::*;
#(
    parameter int          RAM_WORDS  = 4096,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [14:0] MMIO_BASE  = 15'h7FF0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_in,
    output logic [DATA_W-1:0] mem_out,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready
);

    localparam int                RAM_AW    = $clog2(RAM_WORDS);
    localparam logic [ADDR_W-1:0] RAM_LIMIT = ADDR_W'(RAM_WORDS);

    region_e           region;
    logic [3:0]        mmio_off;
    logic [RAM_AW-1:0] ram_idx;
    logic              ram_we;
    logic              con_push;
    logic              stat_wr;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_drop;
    logic              fifo_pop;
    logic [7:0]        fifo_head;
    logic [DATA_W-1:0] status_val;
    logic [DATA_W-1:0] timer_lo_val;
    logic [DATA_W-1:0] timer_hi_val;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] mem_out_q, mem_out_d;
    logic [DATA_W-1:0] ram [RAM_WORDS];

    // Address decode and write strobes per target
    always_comb begin
        region   = decode_region(mem_addr, RAM_LIMIT, MMIO_BASE);
        mmio_off = mem_addr[3:0];
        ram_idx  = mem_addr[RAM_AW-1:0];
        ram_we   = mem_we && (region == REG_RAM) && !rst;
        con_push = mem_we && (region == REG_MMIO) && (mmio_off == OFF_CONSOLE);
        stat_wr  = mem_we && (region == REG_MMIO) && (mmio_off == OFF_STATUS);
    end

    // RAM write port; the read side samples the array before this update lands
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= mem_in;
        end
    end

    assign fifo_pop = tx_valid && tx_ready;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (con_push),
        .din       (mem_in[7:0]),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .push_drop (fifo_drop),
        .head      (fifo_head)
    );

    assign tx_valid = !fifo_empty;
    assign tx_data  = fifo_head;

    // Sticky overflow: set on a dropped byte, cleared by any STATUS write (never both at once)
    always_comb begin
        ovf_d = ovf_q;
        if (stat_wr) begin
            ovf_d = 1'b0;
        end
        if (fifo_drop) begin
            ovf_d = 1'b1;
        end
    end

    // Overflow flag register
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

`ifdef MEM_RESP_TIMER_EN
    logic [31:0]       timer_q,  timer_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;

    // Free-running counter; a TIMER_LO read captures the upper half so TIMER_HI matches it
    always_comb begin
        timer_d  = timer_q + 32'd1;
        shadow_d = shadow_q;
        if ((region == REG_MMIO) && (mmio_off == OFF_TIMER_LO)) begin
            shadow_d = timer_q[31:16];
        end
        timer_lo_val = timer_q[15:0];
        timer_hi_val = shadow_q;
    end

    // Timer and shadow registers
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q  <= '0;
            shadow_q <= '0;
        end else begin
            timer_q  <= timer_d;
            shadow_q <= shadow_d;
        end
    end
`else
    assign timer_lo_val = '0;
    assign timer_hi_val = '0;
`endif

    // Read mux; STATUS reflects flags as they stood before this edge's push/pop
    always_comb begin
        status_val             = '0;
        status_val[STAT_EMPTY] = fifo_empty;
        status_val[STAT_FULL]  = fifo_full;
        status_val[STAT_OVF]   = ovf_q;

        mem_out_d = '0;
        case (region)
            REG_RAM: begin
                mem_out_d = ram[ram_idx];
            end
            REG_MMIO: begin
                case (mmio_off)
                    OFF_STATUS:   mem_out_d = status_val;
                    OFF_TIMER_LO: mem_out_d = timer_lo_val;
                    OFF_TIMER_HI: mem_out_d = timer_hi_val;
                    default:      mem_out_d = '0;
                endcase
            end
            default: begin
                mem_out_d = '0;
            end
        endcase
    end

    // Registered read data
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_out_q <= '0;
        end else begin
            mem_out_q <= mem_out_d;
        end
    end

    assign mem_out = mem_out_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam logic [14:0] A_CON  = 15'h7FF0;
    localparam logic [14:0] A_STAT = 15'h7FF1;
    localparam logic [14:0] A_TLO  = 15'h7FF2;
    localparam logic [14:0] A_THI  = 15'h7FF3;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [15:0] mem_in;
    logic [15:0] mem_out;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_responder dut (
        .clk      (clk),
        .rst      (rst),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_in   (mem_in),
        .mem_out  (mem_out),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [14:0] a, input logic [15:0] d);
        mem_we   = 1'b1;
        mem_addr = a;
        mem_in   = d;
        cyc();
        mem_we   = 1'b0;
    endtask

    task automatic rd(input logic [14:0] a);
        mem_we   = 1'b0;
        mem_addr = a;
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_we = 1'b0; mem_addr = '0; mem_in = '0; tx_ready = 1'b0;
        repeat (3) cyc();
        total++; if (mem_out !== 16'h0000) begin bad++; $display("FAIL reset_mem_out got=%h exp=0000", mem_out); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        rst = 1'b0;
        rd(A_STAT);
        total++; if (mem_out !== 16'h0001) begin bad++; $display("FAIL reset_status got=%h exp=0001", mem_out); end
    endtask

    task automatic test_ram_rw();
        wr(15'h0010, 16'hBEEF);
        rd(15'h0010);
        total++; if (mem_out !== 16'hBEEF) begin bad++; $display("FAIL ram_rd got=%h exp=beef", mem_out); end
    endtask

    task automatic test_read_before_write();
        wr(15'h0020, 16'hAAAA);
        wr(15'h0020, 16'h1234);
        total++; if (mem_out !== 16'hAAAA) begin bad++; $display("FAIL rbw_old got=%h exp=aaaa", mem_out); end
        rd(15'h0020);
        total++; if (mem_out !== 16'h1234) begin bad++; $display("FAIL rbw_new got=%h exp=1234", mem_out); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp;
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            mem_we = 1'b1; mem_addr = A_CON; mem_in = 16'h0041 + 16'(i);
            if (i == 0) begin
                total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL no_fallthru got=%b exp=0", tx_valid); end
            end
            cyc();
            if (i == 0) begin
                total++; if ({tx_valid, tx_data} !== 9'h141) begin bad++; $display("FAIL first_push got=%b/%h exp=1/41", tx_valid, tx_data); end
            end
        end
        rd(A_STAT);
        total++; if (mem_out !== 16'h0006) begin bad++; $display("FAIL ovf_status got=%h exp=0006", mem_out); end
        mem_addr = 15'h0000;
        for (int i = 0; i < 8; i++) begin
            exp = 8'(8'h41 + i);
            total++; if ({tx_valid, tx_data} !== {1'b1, exp}) begin bad++; $display("FAIL drain_%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, exp); end
            tx_ready = 1'b1;
            cyc();
        end
        tx_ready = 1'b0;
        total++; if ({tx_valid, tx_data} !== 9'h000) begin bad++; $display("FAIL drained got=%b/%h exp=0/00", tx_valid, tx_data); end
        rd(A_STAT);
        total++; if (mem_out !== 16'h0005) begin bad++; $display("FAIL ovf_sticky got=%h exp=0005", mem_out); end
        wr(A_STAT, 16'h0000);
        rd(A_STAT);
        total++; if (mem_out !== 16'h0001) begin bad++; $display("FAIL ovf_cleared got=%h exp=0001", mem_out); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp;
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) wr(A_CON, 16'h0050 + 16'(i));
        rd(A_STAT);
        total++; if (mem_out !== 16'h0002) begin bad++; $display("FAIL full_status got=%h exp=0002", mem_out); end
        mem_we = 1'b1; mem_addr = A_CON; mem_in = 16'h005A; tx_ready = 1'b1;
        cyc();
        mem_we = 1'b0; tx_ready = 1'b0;
        rd(A_STAT);
        total++; if (mem_out !== 16'h0002) begin bad++; $display("FAIL full_pop_status got=%h exp=0002", mem_out); end
        for (int i = 0; i < 8; i++) begin
            exp = (i == 7) ? 8'h5A : 8'(8'h51 + i);
            total++; if ({tx_valid, tx_data} !== {1'b1, exp}) begin bad++; $display("FAIL fp_drain_%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, exp); end
            tx_ready = 1'b1;
            cyc();
        end
        tx_ready = 1'b0;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL fp_empty got=%b exp=0", tx_valid); end
    endtask

    task automatic test_reset_midstream();
        tx_ready = 1'b0;
        wr(15'h0030, 16'h7777);
        for (int i = 0; i < 4; i++) wr(A_CON, 16'h0060 + 16'(i));
        total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL half_full got=%b exp=1", tx_valid); end
        rst = 1'b1; mem_we = 1'b1; mem_addr = 15'h0030; mem_in = 16'hDEAD;
        cyc();
        mem_addr = A_CON; mem_in = 16'h0099;
        cyc();
        rst = 1'b0; mem_we = 1'b0;
        total++; if ({tx_valid, tx_data} !== 9'h000) begin bad++; $display("FAIL rst_fifo got=%b/%h exp=0/00", tx_valid, tx_data); end
        total++; if (mem_out !== 16'h0000) begin bad++; $display("FAIL rst_mem_out got=%h exp=0000", mem_out); end
        rd(15'h0030);
        total++; if (mem_out !== 16'h7777) begin bad++; $display("FAIL rst_ram_kept got=%h exp=7777", mem_out); end
        rd(A_STAT);
        total++; if (mem_out !== 16'h0001) begin bad++; $display("FAIL rst_status got=%h exp=0001", mem_out); end
    endtask

    task automatic test_map();
        wr(15'h0000, 16'h1111);
        wr(15'h0FFF, 16'h2222);
        wr(15'h1000, 16'h5555);
        wr(15'h7000, 16'hFFFF);
        rd(15'h0000);
        total++; if (mem_out !== 16'h1111) begin bad++; $display("FAIL map_ram0 got=%h exp=1111", mem_out); end
        rd(15'h0FFF);
        total++; if (mem_out !== 16'h2222) begin bad++; $display("FAIL map_ramtop got=%h exp=2222", mem_out); end
        rd(15'h1000);
        total++; if (mem_out !== 16'h0000) begin bad++; $display("FAIL map_1000 got=%h exp=0000", mem_out); end
        rd(15'h7000);
        total++; if (mem_out !== 16'h0000) begin bad++; $display("FAIL map_7000 got=%h exp=0000", mem_out); end
        rd(A_CON);
        total++; if (mem_out !== 16'h0000) begin bad++; $display("FAIL map_console got=%h exp=0000", mem_out); end
        rd(15'h7FF5);
        total++; if (mem_out !== 16'h0000) begin bad++; $display("FAIL map_mmio5 got=%h exp=0000", mem_out); end
    endtask

    task automatic test_timer();
        rst = 1'b1; mem_we = 1'b0; mem_addr = 15'h0000;
        cyc();
        rst = 1'b0;
`ifdef MEM_RESP_TIMER_EN
        // counter holds 0 after the reset edge; after 0xFFFF idle edges it holds 0xFFFF
        repeat (16'hFFFF) cyc();
        rd(A_TLO);
        total++; if (mem_out !== 16'hFFFF) begin bad++; $display("FAIL timer_lo1 got=%h exp=ffff", mem_out); end
        rd(A_THI);
        total++; if (mem_out !== 16'h0000) begin bad++; $display("FAIL timer_hi1 got=%h exp=0000", mem_out); end
        rd(A_TLO);
        total++; if (mem_out !== 16'h0001) begin bad++; $display("FAIL timer_lo2 got=%h exp=0001", mem_out); end
        rd(A_THI);
        total++; if (mem_out !== 16'h0001) begin bad++; $display("FAIL timer_hi2 got=%h exp=0001", mem_out); end
`else
        repeat (20) cyc();
        rd(A_TLO);
        total++; if (mem_out !== 16'h0000) begin bad++; $display("FAIL timer_lo_off got=%h exp=0000", mem_out); end
        rd(A_THI);
        total++; if (mem_out !== 16'h0000) begin bad++; $display("FAIL timer_hi_off got=%h exp=0000", mem_out); end
`endif
    endtask

    initial begin
        test_reset();
        test_ram_rw();
        test_read_before_write();
        test_overflow();
        test_full_push_pop();
        test_reset_midstream();
        test_map();
        test_timer();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
